mem_boot_loader: RTL
====================

// Module: mem_boot_loader
// PURPOSE
//  Initiator for the shared 256x8 instruction/data memory's data-side write port. Takes a
//  byte stream (valid/ready) of header+payload and writes the payload into memory at
//  absolute addresses, holding the CPU in reset until the load completes.
//  The memory adds DATA_BASE to every data-port address, so this block emits
//  (abs_addr - DATA_BASE) mod 2^ADDR_W to reach any absolute location.
// PARAMETERS
//  ADDR_W     8    memory address width; all address arithmetic is mod 2^ADDR_W
//  DATA_W     8    memory word width = stream byte width
//  DATA_BASE  128  offset the memory adds to the data-port address
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       asynchronous, active-low reset
//  start       in   1       single-cycle pulse: begin a load session
//  in_data     in   DATA_W  stream byte
//  in_valid    in   1       in_data valid
//  in_ready    out  1       loader accepts in_data this cycle
//  mem_d_addr  out  ADDR_W  to memory D_addr (offset form)
//  mem_wdata   out  DATA_W  to memory Wdata
//  mem_wen     out  1       to memory WEn
//  busy        out  1       session in progress (GET_ADDR/GET_LEN/WRITE)
//  load_done   out  1       last session completed
//  cpu_hold    out  1       1 = keep processor in reset
// BEHAVIOUR
//  Reset (async, rst=0): state IDLE; in_ready=0, mem_wen=0, mem_d_addr=0, mem_wdata=0,
//   busy=0, load_done=0, cpu_hold=1; ptr=0, remaining=0. mem_wen drops immediately.
//  Transfer: byte accepted at a rising edge with in_valid & in_ready; no other edge counts.
//  FSM (registered outputs):
//   IDLE: in_ready=0. start -> GET_ADDR, busy=1, cpu_hold=1.
//   GET_ADDR: in_ready=1. accepted byte -> ptr; -> GET_LEN.
//   GET_LEN: in_ready=1. accepted byte L -> remaining = (L==0)?256:L (9-bit); -> WRITE.
//   WRITE: in_ready=1. per accepted byte b: mem_wdata<=b,
//     mem_d_addr<=(ptr-DATA_BASE) mod 2^ADDR_W, mem_wen<=1, ptr<=ptr+1 (255 wraps to 0),
//     remaining<=remaining-1. On acceptance with remaining==1 -> DONE.
//   DONE: in_ready=0, busy=0, load_done=1, cpu_hold=0. start -> GET_ADDR,
//     load_done<=0, cpu_hold<=1, busy<=1.
//  mem_wen is high for exactly the cycle after each accepted payload byte and low otherwise
//   (memory commits at the following edge); throughput 1 byte/cycle, back-to-back allowed.
//  Write latency: byte accepted at edge k -> outputs valid after k -> memory written at k+1.
//  in_valid gaps: mem_wen=0 on those cycles; ptr/remaining hold.
//  start while busy: ignored. start in same cycle as rst low: reset wins.
//  Reset mid-session: abort, no further writes, memory contents already written are kept.
//  Header bytes never assert mem_wen.
// TESTING
//  T1 reset: rst=0 with in_valid=1 -> in_ready=0, mem_wen=0, cpu_hold=1, load_done=0.
//  T2 basic: start; stream 0x00,0x03,0xA1,0xA2,0xA3 back-to-back -> mem_d_addr 0x80,0x81,0x82,
//     wdata A1..A3, 3 single-cycle wen pulses; mem[0..2]=A1..A3; load_done=1, cpu_hold=0.
//  T3 wrap: header 0xFE,0x04, payload 11,22,33,44 -> abs 0xFE,0xFF,0x00,0x01,
//     mem_d_addr 0x7E,0x7F,0x80,0x81.
//  T4 len 0: header 0x00,0x00 + 256 bytes i -> 256 wen pulses, mem[i]=i, DONE only after byte 255.
//  T5 stalls: drop in_valid 2 cycles between payload bytes -> no wen in gaps, addresses contiguous.
//  T6 abort/restart: rst=0 after 2 of 5 payload bytes -> wen low at once; new session after
//     start rewrites correctly; start pulses during WRITE ignored.

Source files
------------

// File: rtl/mem_boot_loader_if.sv
// rtl/mem_boot_loader_if.sv - stream input, memory write port and status bundle for mem_boot_loader
interface mem_boot_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_d_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wen;
  logic              busy;
  logic              load_done;
  logic              cpu_hold;

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, mem_d_addr, mem_wdata, mem_wen, busy, load_done, cpu_hold
  );

  modport master (
    output start, in_data, in_valid,
    input  in_ready, mem_d_addr, mem_wdata, mem_wen, busy, load_done, cpu_hold
  );
endinterface

// File: rtl/mem_boot_loader.sv
// rtl/mem_boot_loader.sv - header+payload byte stream loader into the shared memory's data port
module mem_boot_loader #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int DATA_BASE = 128
) (
  input  logic              clk,
  input  logic              rst,
  mem_boot_loader_if.slave  bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_GET_ADDR = 3'd1;
  localparam logic [2:0] S_GET_LEN  = 3'd2;
  localparam logic [2:0] S_WRITE    = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  localparam logic [ADDR_W-1:0] BASE_OFS = ADDR_W'(DATA_BASE);
  localparam logic [ADDR_W:0]   REM_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic [2:0]        state_q,     state_d;
  logic [ADDR_W-1:0] ptr_q,       ptr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [DATA_W-1:0] wdata_q,     wdata_d;
  logic              wen_q,       wen_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  logic              hold_q,      hold_d;
  logic              accept;

  // busy covers exactly the states that take stream bytes, so it doubles as in_ready
  assign accept = bus.in_valid && busy_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wen_d       = 1'b0;
    busy_d      = busy_q;
    done_d      = done_q;
    hold_d      = hold_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_GET_ADDR;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          hold_d  = 1'b1;
        end
      end
      S_GET_ADDR: begin
        if (accept) begin
          ptr_d   = ADDR_W'(bus.in_data);
          state_d = S_GET_LEN;
        end
      end
      S_GET_LEN: begin
        if (accept) begin
          // a zero length byte means a full 2^ADDR_W byte image
          remaining_d = (bus.in_data == '0) ? REM_FULL : (ADDR_W + 1)'(bus.in_data);
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        if (accept) begin
          wdata_d     = bus.in_data;
          addr_d      = ptr_q - BASE_OFS;
          wen_d       = 1'b1;
          ptr_d       = ptr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == REM_ONE) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        hold_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wen_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      hold_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wen_q       <= wen_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      hold_q      <= hold_d;
    end
  end

  assign bus.in_ready   = busy_q;
  assign bus.mem_d_addr = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.mem_wen    = wen_q;
  assign bus.busy       = busy_q;
  assign bus.load_done  = done_q;
  assign bus.cpu_hold   = hold_q;

endmodule
